// File: rtl/sample_angle_interpolator_pkg.sv
// Shared types and default constants for the sample angle interpolator.
// Angles are in 1/64 degree units, so one revolution is 360 x 64.
package sample_angle_interpolator_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        DIVIDE,
        EMIT,
        DONE
    } state_e;

    localparam int DEFAULT_FULL_SCALE = 23040;
    localparam int DEFAULT_MAX_SPAN   = 5760;

endpackage

// File: rtl/angle_divider.sv
// Unsigned restoring divider producing one quotient bit per cycle.
// The first bit is resolved on the start edge, so valid_out rises exactly WIDTH cycles after start_in.
module angle_divider #(
    parameter int WIDTH = 16
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             start_in,
    input  logic [WIDTH-1:0] dividend_in,
    input  logic [WIDTH-1:0] divisor_in,
    output logic [WIDTH-1:0] quotient_out,
    output logic [WIDTH-1:0] remainder_out,
    output logic             valid_out
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic             valid_q;

    // The quotient register doubles as the dividend shift register.
    function automatic logic [2*WIDTH-1:0] div_step(input logic [WIDTH-1:0] rem,
                                                    input logic [WIDTH-1:0] dvd,
                                                    input logic [WIDTH-1:0] dvs);
        logic [WIDTH:0] shifted;
        shifted = {rem, dvd[WIDTH-1]};
        if (shifted >= {1'b0, dvs}) begin
            return {WIDTH'(shifted - {1'b0, dvs}), dvd[WIDTH-2:0], 1'b1};
        end else begin
            return {shifted[WIDTH-1:0], dvd[WIDTH-2:0], 1'b0};
        end
    endfunction

    always_comb begin
        rem_d = '0;
        quo_d = '0;
        if (start_in) begin
            {rem_d, quo_d} = div_step('0, dividend_in, divisor_in);
        end else begin
            {rem_d, quo_d} = div_step(rem_q, quo_q, dvs_q);
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (start_in) begin
                rem_q  <= rem_d;
                quo_q  <= quo_d;
                dvs_q  <= divisor_in;
                cnt_q  <= CW'(WIDTH - 1);
                busy_q <= 1'b1;
            end else if (busy_q) begin
                rem_q <= rem_d;
                quo_q <= quo_d;
                cnt_q <= cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    busy_q  <= 1'b0;
                    valid_q <= 1'b1;
                end
            end
        end
    end

    assign quotient_out  = quo_q;
    assign remainder_out = rem_q;
    assign valid_out     = valid_q;

endmodule

// File: rtl/sample_angle_interpolator.sv
// Spreads N sample angles evenly between a first and last angle, wrapping at one revolution.
// The span is split into a quotient step plus a Bresenham-style remainder so the last sample lands exactly.
module sample_angle_interpolator
    import sample_angle_interpolator_pkg::*;
#(
    parameter int ANGLE_W    = 16,
    parameter int FULL_SCALE = DEFAULT_FULL_SCALE,
    parameter int MAX_SPAN   = DEFAULT_MAX_SPAN,
    parameter int CNT_W      = 16
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic [ANGLE_W-1:0] first_angle_in,
    input  logic [ANGLE_W-1:0] last_angle_in,
    input  logic [CNT_W-1:0]   sample_num_in,
    input  logic               data_valid_in,
    output logic [ANGLE_W-1:0] angle_out,
    output logic [CNT_W-1:0]   index_out,
    output logic               angle_valid_out,
    input  logic               angle_ready_in,
    output logic               last_out,
    output logic [ANGLE_W-1:0] interval_out,
    output logic               done_out,
    output logic               error_out,
    output logic               busy_out
);

    localparam logic [ANGLE_W:0] FS_X = FULL_SCALE[ANGLE_W:0];
    localparam logic [ANGLE_W:0] MS_X = MAX_SPAN[ANGLE_W:0];

    state_e state_q, state_d;

    logic [ANGLE_W-1:0] first_q, last_q, angle_q, angle_d, interval_q;
    logic [CNT_W-1:0]   n_q, nm1, index_q, err_q, err_d, rem_q;
    logic               error_q;
    logic [ANGLE_W:0]   delta, step, angle_sum;
    logic [CNT_W:0]     err_sum;
    logic               reject, is_last, transfer, div_start, div_valid;
    logic [ANGLE_W-1:0] div_quo, div_rem;

    assign nm1       = n_q - CNT_W'(1);
    assign is_last   = (index_q == nm1);
    assign transfer  = (state_q == EMIT) && angle_ready_in;
    assign div_start = (state_q == CHECK) && !reject && (n_q != CNT_W'(1));

    always_comb begin
        delta = '0;
        if (last_q >= first_q) begin
            delta = {1'b0, last_q} - {1'b0, first_q};
        end else begin
            delta = {1'b0, last_q} + FS_X - {1'b0, first_q};
        end
        reject = (n_q == '0) || ({1'b0, first_q} >= FS_X) ||
                 ({1'b0, last_q} >= FS_X) || (delta > MS_X);
    end

    // Remainder accumulator decides whether this step carries one extra unit.
    always_comb begin
        err_sum = {1'b0, err_q} + {1'b0, rem_q};
        err_d   = err_sum[CNT_W-1:0];
        step    = {1'b0, interval_q};
        if (err_sum >= {1'b0, nm1}) begin
            err_d = CNT_W'(err_sum - {1'b0, nm1});
            step  = {1'b0, interval_q} + (ANGLE_W+1)'(1);
        end
        angle_sum = {1'b0, angle_q} + step;
        angle_d   = angle_sum[ANGLE_W-1:0];
        if (angle_sum >= FS_X) begin
            angle_d = ANGLE_W'(angle_sum - FS_X);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (data_valid_in) state_d = CHECK;
            CHECK: begin
                if (reject)                  state_d = DONE;
                else if (n_q == CNT_W'(1))   state_d = EMIT;
                else                         state_d = DIVIDE;
            end
            DIVIDE: if (div_valid) state_d = EMIT;
            EMIT:   if (transfer && is_last) state_d = DONE;
            DONE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            first_q    <= '0;
            last_q     <= '0;
            n_q        <= '0;
            angle_q    <= '0;
            index_q    <= '0;
            err_q      <= '0;
            rem_q      <= '0;
            interval_q <= '0;
            error_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (data_valid_in) begin
                        first_q <= first_angle_in;
                        last_q  <= last_angle_in;
                        n_q     <= sample_num_in;
                        angle_q <= first_angle_in;
                        index_q <= '0;
                        err_q   <= '0;
                        error_q <= 1'b0;
                    end
                end
                CHECK: begin
                    if (reject) begin
                        error_q <= 1'b1;
                    end else if (n_q == CNT_W'(1)) begin
                        interval_q <= '0;
                        rem_q      <= '0;
                    end
                end
                DIVIDE: begin
                    if (div_valid) begin
                        interval_q <= div_quo;
                        rem_q      <= CNT_W'(div_rem);
                    end
                end
                EMIT: begin
                    if (transfer && !is_last) begin
                        index_q <= index_q + CNT_W'(1);
                        angle_q <= angle_d;
                        err_q   <= err_d;
                    end
                end
                default: ;
            endcase
        end
    end

    angle_divider #(
        .WIDTH(ANGLE_W)
    ) u_divider (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .start_in     (div_start),
        .dividend_in  (delta[ANGLE_W-1:0]),
        .divisor_in   (ANGLE_W'(nm1)),
        .quotient_out (div_quo),
        .remainder_out(div_rem),
        .valid_out    (div_valid)
    );

    assign angle_out       = angle_q;
    assign index_out       = index_q;
    assign angle_valid_out = (state_q == EMIT);
    assign last_out        = angle_valid_out && is_last;
    assign interval_out    = interval_q;
    assign done_out        = (state_q == DONE);
    assign error_out       = done_out && error_q;
    assign busy_out        = (state_q != IDLE);

endmodule

// File: tb/tb_sample_angle_interpolator.sv
// Directed self-checking bench for sample_angle_interpolator with hand-computed angle tables.
module tb_sample_angle_interpolator;

    localparam int ANGLE_W = 16;
    localparam int CNT_W   = 16;

    logic               clk_in = 1'b0;
    logic               rst_in;
    logic [ANGLE_W-1:0] first_angle_in, last_angle_in;
    logic [CNT_W-1:0]   sample_num_in;
    logic               data_valid_in;
    logic [ANGLE_W-1:0] angle_out, interval_out;
    logic [CNT_W-1:0]   index_out;
    logic               angle_valid_out, angle_ready_in, last_out;
    logic               done_out, error_out, busy_out;

    int checkCount  = 0;
    int errorCount  = 0;
    int expAngle[16];

    always #5 clk_in = ~clk_in;

    sample_angle_interpolator dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .first_angle_in (first_angle_in),
        .last_angle_in  (last_angle_in),
        .sample_num_in  (sample_num_in),
        .data_valid_in  (data_valid_in),
        .angle_out      (angle_out),
        .index_out      (index_out),
        .angle_valid_out(angle_valid_out),
        .angle_ready_in (angle_ready_in),
        .last_out       (last_out),
        .interval_out   (interval_out),
        .done_out       (done_out),
        .error_out      (error_out),
        .busy_out       (busy_out)
    );

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic waitCycle();
        @(posedge clk_in);
        #1;
    endtask

    task automatic applyStimulus(input int first, input int last, input int n);
        first_angle_in = ANGLE_W'(first);
        last_angle_in  = ANGLE_W'(last);
        sample_num_in  = CNT_W'(n);
        data_valid_in  = 1'b1;
        waitCycle();
        data_valid_in  = 1'b0;
    endtask

    // Runs one request; resetAt < 0 lets the packet complete, otherwise reset is applied at that index.
    task automatic runPacket(input string name, input int first, input int last, input int n,
                             input int expInterval, input bit expError, input bit randomReady,
                             input int resetAt);
        int  lat;
        int  cyc;
        int  tries;
        bit  early;
        bit  rdy;
        checkOutput({name, " idle before request"}, busy_out, 0);
        applyStimulus(first, last, n);
        if (expError) begin
            checkOutput({name, " no done in check"}, done_out, 0);
            waitCycle();
            checkOutput({name, " done"}, done_out, 1);
            checkOutput({name, " error"}, error_out, 1);
            checkOutput({name, " no valid"}, angle_valid_out, 0);
            waitCycle();
            checkOutput({name, " idle after"}, busy_out, 0);
            return;
        end
        lat   = (n == 1) ? 2 : ANGLE_W + 2;
        cyc   = 1;
        early = 1'b0;
        while (cyc < lat) begin
            if (angle_valid_out) early = 1'b1;
            waitCycle();
            cyc++;
        end
        checkOutput({name, " no early valid"}, early, 0);
        for (int i = 0; i < n; i++) begin
            if (i == resetAt) begin
                angle_ready_in = 1'b0;
                rst_in = 1'b1;
                waitCycle();
                rst_in = 1'b0;
                checkOutput({name, " busy after reset"}, busy_out, 0);
                checkOutput({name, " valid after reset"}, angle_valid_out, 0);
                checkOutput({name, " done after reset"}, done_out, 0);
                checkOutput({name, " angle after reset"}, angle_out, 0);
                checkOutput({name, " index after reset"}, index_out, 0);
                return;
            end
            tries = 0;
            do begin
                rdy = randomReady ? ($urandom_range(0, 1) == 1) : 1'b1;
                if (tries >= 6) rdy = 1'b1;
                angle_ready_in = rdy;
                checkOutput({name, " valid"}, angle_valid_out, 1);
                checkOutput({name, " angle"}, angle_out, expAngle[i]);
                checkOutput({name, " index"}, index_out, i);
                checkOutput({name, " last"}, last_out, (i == n - 1) ? 1 : 0);
                checkOutput({name, " interval"}, interval_out, expInterval);
                waitCycle();
                tries++;
            end while (!rdy);
        end
        angle_ready_in = 1'b0;
        checkOutput({name, " done"}, done_out, 1);
        checkOutput({name, " error"}, error_out, 0);
        checkOutput({name, " valid in done"}, angle_valid_out, 0);
        data_valid_in = 1'b1;
        waitCycle();
        data_valid_in = 1'b0;
        checkOutput({name, " request during done ignored"}, busy_out, 0);
        checkOutput({name, " done is one pulse"}, done_out, 0);
    endtask

    initial begin
        rst_in         = 1'b1;
        first_angle_in = '0;
        last_angle_in  = '0;
        sample_num_in  = '0;
        data_valid_in  = 1'b0;
        angle_ready_in = 1'b0;
        repeat (3) waitCycle();
        rst_in = 1'b0;
        checkOutput("reset busy", busy_out, 0);
        checkOutput("reset valid", angle_valid_out, 0);
        checkOutput("reset done", done_out, 0);
        checkOutput("reset error", error_out, 0);
        checkOutput("reset angle", angle_out, 0);
        checkOutput("reset index", index_out, 0);
        checkOutput("reset interval", interval_out, 0);

        expAngle = '{1000, 1100, 1200, 1300, 1400, 1500, 1600, 1700,
                     1800, 1900, 0, 0, 0, 0, 0, 0};
        runPacket("linear", 1000, 1900, 10, 100, 1'b0, 1'b0, -1);

        expAngle = '{22000, 22510, 23020, 490, 1000, 0, 0, 0,
                     0, 0, 0, 0, 0, 0, 0, 0};
        runPacket("wrap", 22000, 1000, 5, 510, 1'b0, 1'b0, -1);

        expAngle = '{0, 3, 6, 10, 0, 0, 0, 0,
                     0, 0, 0, 0, 0, 0, 0, 0};
        runPacket("remainder", 0, 10, 4, 3, 1'b0, 1'b0, -1);

        expAngle = '{777, 0, 0, 0, 0, 0, 0, 0,
                     0, 0, 0, 0, 0, 0, 0, 0};
        runPacket("single", 777, 777, 1, 0, 1'b0, 1'b0, -1);

        runPacket("span too big", 100, 12000, 8, 0, 1'b1, 1'b0, -1);
        runPacket("zero samples", 0, 10, 0, 0, 1'b1, 1'b0, -1);
        runPacket("angle out of range", 23040, 100, 2, 0, 1'b1, 1'b0, -1);

        expAngle = '{1000, 1100, 1200, 1300, 1400, 1500, 1600, 1700,
                     1800, 1900, 0, 0, 0, 0, 0, 0};
        runPacket("backpressure reset", 1000, 1900, 10, 100, 1'b0, 1'b1, 4);

        expAngle = '{0, 3, 6, 10, 0, 0, 0, 0,
                     0, 0, 0, 0, 0, 0, 0, 0};
        runPacket("after reset", 0, 10, 4, 3, 1'b0, 1'b1, -1);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
